// File: rtl/bci_pkg.sv
// Shared types for the epoch collector: sample type, default sizing and FSM state encodings.
package bci_pkg;

    typedef logic signed [31:0] sample_t;

    localparam int EPOCH_LEN_DEF     = 256;
    localparam int SETTLE_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETTLE,
        WR_FILL
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_state_t;

endpackage

// File: rtl/epoch_bank_ram.sv
// Two-bank simple dual-port sample buffer. Address is {bank, idx}.
// Synchronous write, registered read; rdata holds its value while re is low,
// which lets the reader pipeline stall simply by not issuing.
module epoch_bank_ram
    import bci_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W:0]    waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W:0]    raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**(IDX_W+1)];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/epoch_collector.sv
// Collects filtered samples into fixed-length epochs held in a ping-pong buffer
// and streams each completed epoch out over ready/valid with a last marker.
// Optional build macro EPOCH_PEAK_EN adds the epoch_peak output (max |sample|
// of the epoch being drained).
module epoch_collector
    import bci_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int EPOCH_LEN     = EPOCH_LEN_DEF,     // power of two, >= 4
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF  // >= 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    output logic                     filt_enable,
    input  logic                     filt_valid,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_last,
    output logic                     overflow,
    output logic [15:0]              epoch_count
`ifdef EPOCH_PEAK_EN
    ,
    output logic [DATA_W-1:0]        epoch_peak
`endif
);

    localparam int IDX_W = $clog2(EPOCH_LEN);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(EPOCH_LEN - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    // ---------------- writer ----------------
    wr_state_t        wr_state, wr_state_nx;
    logic [SET_W-1:0] settle_cnt;
    logic [IDX_W-1:0] widx;
    logic             wbank;
    logic             run_q;
    logic             wr_en, wr_drop, wr_wrap;
    logic [1:0]       full;

    // ---------------- reader ----------------
    rd_state_t        rd_state, rd_state_nx;
    logic [IDX_W-1:0] ridx;
    logic             rbank;      // bank being issued to the RAM
    logic             done_bank;  // bank whose samples are on the output
    logic             adv, issue, iss_last, done_xfer;
    logic [1:0]       vld_pipe;   // [0] RAM read data valid, [1] output valid
    logic [1:0]       last_pipe;
    logic [DATA_W-1:0] ram_q;
    logic [1:0]       full_set, full_clr;

    // Writer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= WR_IDLE;
        else        wr_state <= wr_state_nx;
    end

    // Writer next state: dropping run flushes from any state
    always_comb begin
        wr_state_nx = wr_state;
        if (!run) begin
            wr_state_nx = WR_IDLE;
        end else begin
            case (wr_state)
                WR_IDLE:   wr_state_nx = WR_SETTLE;
                WR_SETTLE: if (filt_valid && settle_cnt == SETTLE_LAST) wr_state_nx = WR_FILL;
                default:   ;
            endcase
        end
    end

    // Writer outputs: filter enable follows the state, so it changes one cycle after run
    always_comb begin
        filt_enable = 1'b0;
        wr_en       = 1'b0;
        wr_drop     = 1'b0;
        case (wr_state)
            WR_SETTLE: filt_enable = 1'b1;
            WR_FILL: begin
                filt_enable = 1'b1;
                if (run && filt_valid) begin
                    if (full[wbank]) wr_drop = 1'b1;
                    else             wr_en   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign wr_wrap = wr_en && (widx == IDX_LAST);

    // Writer counters, bank pointer and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            widx       <= '0;
            wbank      <= 1'b0;
            run_q      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            run_q <= run;
            if (wr_state != WR_SETTLE) settle_cnt <= '0;
            else if (filt_valid)       settle_cnt <= settle_cnt + 1'b1;
            // A flush abandons the partial bank; wbank stays so the same bank refills next
            if (wr_state != WR_FILL || !run) widx <= '0;
            else if (wr_en)                  widx <= wr_wrap ? '0 : widx + 1'b1;
            if (wr_wrap) wbank <= ~wbank;
            if (run && !run_q) overflow <= 1'b0;
            else if (wr_drop)  overflow <= 1'b1;
        end
    end

    // Writer and reader never complete the same bank in one cycle, so set/clear cannot collide
    assign full_set = {wr_wrap & wbank, wr_wrap & ~wbank};
    assign full_clr = {done_xfer & done_bank, done_xfer & ~done_bank};

    // Bank-full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full <= 2'b00;
        else        full <= (full | full_set) & ~full_clr;
    end

    epoch_bank_ram #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wbank, widx}),
        .wdata (filt_data),
        .re    (issue),
        .raddr ({rbank, ridx}),
        .rdata (ram_q)
    );

    // Reader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_state_nx;
    end

    // Reader next state: banks are consumed strictly alternately, so the
    // oldest full bank is always the one rbank points at
    always_comb begin
        rd_state_nx = rd_state;
        case (rd_state)
            RD_IDLE:  if (full[rbank]) rd_state_nx = RD_DRAIN;
            RD_DRAIN: if (iss_last && !full[~rbank]) rd_state_nx = RD_IDLE;
            default:  rd_state_nx = RD_IDLE;
        endcase
    end

    // Reader outputs: issue a read whenever the two-stage output pipe can move
    always_comb begin
        adv      = !vld_pipe[1] || rd_ready;
        issue    = (rd_state == RD_DRAIN) && adv;
        iss_last = issue && (ridx == IDX_LAST);
    end

    assign rd_valid  = vld_pipe[1];
    assign rd_last   = last_pipe[1];
    assign done_xfer = rd_valid && rd_ready && rd_last;

    // Read pointer; staying in DRAIN across iss_last gives zero-bubble epoch chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ridx  <= '0;
            rbank <= 1'b0;
        end else begin
            if (issue)    ridx  <= ridx + 1'b1;
            if (iss_last) rbank <= ~rbank;
        end
    end

    // Prefetch pipe: RAM stage and output stage stall together when the output is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= 2'b00;
            last_pipe <= 2'b00;
            rd_data   <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[0], issue};
            last_pipe <= {last_pipe[0], iss_last};
            if (vld_pipe[0]) rd_data <= ram_q;
        end
    end

    // Epoch completion bookkeeping on the last output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_bank   <= 1'b0;
            epoch_count <= '0;
        end else if (done_xfer) begin
            done_bank   <= ~done_bank;
            epoch_count <= epoch_count + 1'b1;
        end
    end

`ifdef EPOCH_PEAK_EN
    logic [1:0][DATA_W-1:0] peak;
    logic [DATA_W-1:0]      samp_abs;

    // |sample| with the most negative value saturating to the largest positive
    always_comb begin
        samp_abs = filt_data;
        if (filt_data == {1'b1, {(DATA_W-1){1'b0}}}) samp_abs = {1'b0, {(DATA_W-1){1'b1}}};
        else if (filt_data[DATA_W-1])                samp_abs = -filt_data;
    end

    // Running peak per bank; the first sample of an epoch restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (wr_en) begin
            if (widx == '0 || samp_abs > peak[wbank]) peak[wbank] <= samp_abs;
        end
    end

    // A full bank is never rewritten, so this is stable across the drain
    assign epoch_peak = peak[done_bank];
`endif

endmodule

// File: tb/tb_epoch_collector.sv
// Directed bench for epoch_collector with EPOCH_LEN=4, SETTLE_CYCLES=2.
module tb_epoch_collector;
    import bci_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        filt_enable;
    logic        filt_valid;
    sample_t     filt_data;
    logic        rd_valid;
    logic        rd_ready;
    sample_t     rd_data;
    logic        rd_last;
    logic        overflow;
    logic [15:0] epoch_count;
`ifdef EPOCH_PEAK_EN
    logic [31:0] epoch_peak;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          src_val, src_max;
    bit          peak_mode = 1'b0;
    sample_t     peak_tab [6];
    logic [31:0] got_q [$];
    bit          lst_q [$];

    epoch_collector #(
        .DATA_W        (32),
        .EPOCH_LEN     (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .filt_enable (filt_enable),
        .filt_valid  (filt_valid),
        .filt_data   (filt_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .overflow    (overflow),
        .epoch_count (epoch_count)
`ifdef EPOCH_PEAK_EN
        ,
        .epoch_peak  (epoch_peak)
`endif
    );

    always #5 clk = ~clk;

    // Record every output transfer; inputs are stable at the falling edge
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            got_q.push_back(rd_data);
            lst_q.push_back(rd_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; the filter model presents the next value while enabled
    task automatic tick();
        @(posedge clk);
        #1;
        if (filt_enable && src_val <= src_max) begin
            filt_valid = 1'b1;
            if (peak_mode) filt_data = peak_tab[src_val];
            else           filt_data = sample_t'(src_val);
            src_val++;
        end else begin
            filt_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) tick();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    // Expect consecutive values first..first+n-1, last on every 4th
    task automatic chk_seq(input string tag, input int first, input int n);
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s_d%0d", tag, i), got_q[i], first + i);
                chk($sformatf("%s_l%0d", tag, i), lst_q[i], (i % 4) == 3);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; run = 1'b0; rd_ready = 1'b0; filt_valid = 1'b0;
        peak_mode = 1'b0;
        idle(2);
        rst_n = 1'b1;
        got_q.delete(); lst_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; rd_ready = 1'b0;
        filt_valid = 1'b0; filt_data = '0;
        src_val = 1; src_max = 0;
        peak_tab = '{1, 1, -5, 3, 32'sh80000000, 2};
        #22;
        chk("rst_fen", filt_enable, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdd", rd_data, 0);
        chk("rst_rdl", rd_last, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", epoch_count, 0);

        // 1: continuous stream, always ready
        do_reset();
        src_val = 1; src_max = 10; rd_ready = 1'b1; run = 1'b1;
        chk("t1_fen_pre", filt_enable, 0);
        tick();
        chk("t1_fen_on", filt_enable, 1);
        wait_out(4, 60);
        chk("t1_cnt1", epoch_count, 1);
        wait_out(8, 60);
        idle(10);
        chk_seq("t1", 3, 8);
        chk("t1_cnt2", epoch_count, 2);

        // 2: downstream stalled -> two banks fill, 9th sample overflows
        do_reset();
        src_val = 1; src_max = 11; rd_ready = 1'b0; run = 1'b1;
        for (int c = 0; c < 60 && src_val != 11; c++) tick();
        tick();
        chk("t2_ovf_pre", overflow, 0);
        tick();
        chk("t2_ovf_set", overflow, 1);
        chk("t2_hold_v", rd_valid, 1);
        chk("t2_hold_d", rd_data, 3);
        chk("t2_hold_l", rd_last, 0);
        rd_ready = 1'b1;
        wait_out(8, 60);
        idle(10);
        chk_seq("t2", 3, 8);
        chk("t2_ovf_sticky", overflow, 1);
        chk("t2_cnt", epoch_count, 2);

        // 4: one epoch, then two samples of a partial epoch, then run drop
        got_q.delete(); lst_q.delete();
        src_max = 17;
        for (int c = 0; c < 60 && src_val != 18; c++) tick();
        tick();
        run = 1'b0;
        chk("t4_fen_hold", filt_enable, 1);
        tick();
        chk("t4_fen_off", filt_enable, 0);
        chk("t4_ovf_keep", overflow, 1);
        idle(10);
        chk_seq("t4a", 12, 4);
        chk("t4a_cnt", epoch_count, 3);
        got_q.delete(); lst_q.delete();
        src_max = 27; run = 1'b1;
        tick();
        chk("t4_ovf_clr", overflow, 0);
        chk("t4_fen_re", filt_enable, 1);
        wait_out(8, 80);
        idle(10);
        chk_seq("t4b", 20, 8);
        chk("t4b_cnt", epoch_count, 5);

        // 3: ready toggling during drain
        do_reset();
        src_val = 1; src_max = 6; rd_ready = 1'b0; run = 1'b1;
        for (int c = 0; c < 40 && !rd_valid; c++) tick();
        for (int k = 0; k < 16; k++) begin
            if (rd_valid && got_q.size() < 4) begin
                chk($sformatf("t3_d%0d", k), rd_data, 3 + got_q.size());
                chk($sformatf("t3_l%0d", k), rd_last, got_q.size() == 3);
            end
            rd_ready = (k % 2) == 0;
            tick();
        end
        chk_seq("t3", 3, 4);

        // 5: reset while an epoch is being presented
        got_q.delete(); lst_q.delete();
        src_val = 20; src_max = 23; rd_ready = 1'b0;
        for (int c = 0; c < 40 && !rd_valid; c++) tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rdv", rd_valid, 0);
        chk("t5_rdd", rd_data, 0);
        chk("t5_rdl", rd_last, 0);
        chk("t5_cnt", epoch_count, 0);
        chk("t5_fen", filt_enable, 0);
        idle(2);
        rst_n = 1'b1;
        src_val = 100; src_max = 105; rd_ready = 1'b1;
        idle(3);
        chk("t5_noval", rd_valid, 0);
        wait_out(4, 60);
        idle(10);
        chk_seq("t5", 102, 4);
        chk("t5_cnt1", epoch_count, 1);

`ifdef EPOCH_PEAK_EN
        do_reset();
        peak_mode = 1'b1; src_val = 0; src_max = 5; rd_ready = 1'b1; run = 1'b1;
        for (int c = 0; c < 40 && !rd_valid; c++) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pk%0d", k), epoch_peak, 32'h7FFFFFFF);
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/epoch_collector.md
Name: epoch_collector

Overview:
- Sink for the preprocessor filter chain's streaming output (`valid` / `filter_out`).
- Drives the filter's `enable` input and gathers filtered samples into fixed-length epochs in a ping-pong (two-bank) buffer.
- Presents each completed epoch to the downstream feature extractor over a ready/valid stream with a last marker.

Parameters:
- DATA_W, 32, sample width (signed, Q2.29 as produced by the filter).
- EPOCH_LEN, 256, samples per epoch; power of two, minimum 4.
- SETTLE_CYCLES, 8, valid samples discarded after `run` rises (filter transient).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = acquire, 0 = stop and flush
- filt_enable  out  1  drives filter `enable`
- filt_valid  in  1  filter output valid
- filt_data  in  DATA_W  filter output sample (signed)
- rd_valid  out  1  output sample valid
- rd_ready  in  1  downstream accept
- rd_data  out  DATA_W  epoch sample
- rd_last  out  1  high on the final sample of an epoch
- overflow  out  1  sticky; a sample was dropped because both banks were full
- epoch_count  out  16  completed epochs delivered, wraps at 65535→0

Behaviour:
- Reset values: filt_enable=0, rd_valid=0, rd_data=0, rd_last=0, overflow=0, epoch_count=0. Both banks are empty, writer is in IDLE, reader is in IDLE.

Writer FSM (IDLE, SETTLE, FILL):
- IDLE:
  - filt_enable=0.
  - When run=1: go to SETTLE, set filt_enable=1 on the next cycle, clear the settle counter.
- SETTLE:
  - Count cycles with filt_valid=1; samples are discarded.
  - After SETTLE_CYCLES valid samples, go to FILL targeting the write bank (initially bank 0).
- FILL:
  - Each filt_valid=1 writes filt_data to wbank[widx], then widx++.
  - When widx reaches EPOCH_LEN-1 and is written: mark the bank full, toggle the write bank, set widx=0.
  - If the target bank is still full (not yet drained), the sample is dropped, overflow is set, and widx does not advance.
- run=0 in any state:
  - Next cycle: filt_enable=0, writer goes to IDLE, widx=0, the partially filled bank is discarded (not marked full).
  - Full banks are kept and still drained.

Reader FSM (IDLE, DRAIN):
- IDLE:
  - When any bank is full, select the oldest full bank and go to DRAIN.
  - Ordering: bank 0 first after reset, then strict alternation.
- DRAIN:
  - Standard valid/ready semantics. rd_data, rd_valid and rd_last are registered.
  - rd_data and rd_last hold stable while rd_valid=1 and rd_ready=0.
  - A transfer occurs when rd_valid and rd_ready are both high; ridx++.
  - rd_last=1 when ridx==EPOCH_LEN-1.
  - On the last transfer: clear the bank-full flag, epoch_count++, return to IDLE (or go straight to DRAIN of the other bank if it is already full).
  - Zero bubbles are allowed between back-to-back epochs. Memory read latency is hidden by prefetching one sample ahead.

Throughput and boundaries:
- Throughput is 1 sample/cycle on both sides.
- Latency: the first sample of an epoch appears on rd_valid no earlier than 2 cycles after the full flag sets.
- Simultaneous write-completion of bank X and drain-completion of bank Y in the same cycle: both take effect; no overflow.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); buffered data is lost.
- overflow clears only on reset or on a run 0→1 transition.

Arithmetic:
- No sample arithmetic; samples are stored bit-exact.
- ridx and widx are $clog2(EPOCH_LEN) bits wide.

Optional Feature:
- Macro: EPOCH_PEAK_EN.
- When defined:
  - Adds output port `epoch_peak` [DATA_W-1:0].
  - It carries the maximum |sample| of the epoch currently being drained, computed during fill.
  - One peak register per bank; abs of the most negative value saturates to the maximum positive value.
  - Valid whenever rd_valid=1 and stable for the whole epoch.
- When undefined: the port and registers are absent; all other behaviour is identical.

Decomposition:
- Package `bci_pkg`:
  - `sample_t` (logic signed [31:0]).
  - Default EPOCH_LEN and SETTLE_CYCLES localparams.
  - Writer-state and reader-state enums.
- One sub-module, `epoch_bank_ram`:
  - Two-bank simple dual-port RAM.
  - Synchronous write; 1-cycle registered read.
  - Address is {bank, idx}.

Test Plan (EPOCH_LEN=4, SETTLE_CYCLES=2):
- Reset, run=1, feed continuous samples 1,2,3,…; rd_ready=1 → samples 1,2 discarded. Output 3,4,5,6 with rd_last on 6, then 7,8,9,10. epoch_count increments after each epoch.
- rd_ready=0 throughout with continuous input → two epochs buffered, then overflow=1 on the 9th post-settle sample. After rd_ready=1, the two buffered epochs drain intact and in order.
- rd_ready toggling 1,0,1,0 during drain → rd_data and rd_last hold while stalled; no duplicates or skips.
- Drop run after 2 samples of an epoch, then raise run again → partial epoch never output. filt_enable falls next cycle. Settle repeats; overflow cleared.
- Deassert rst_n mid-drain → all outputs reset immediately; no rd_valid until a new full epoch.
- With EPOCH_PEAK_EN: epoch samples -5, 3, 0x80000000, 2 → epoch_peak = 0x7FFFFFFF throughout that epoch's drain.
